// File: rtl/bsg_cover_packetizer.sv
// bsg_cover_packetizer
// Collects drain bursts from num_chan_p coverage streams and forwards them to one
// host-bound stream. Channels are served round-robin. Each burst is preceded by a
// header word {zeros, chan[7:0], els[7:0], len[7:0]}. The burst's beat count is
// checked against els*len, and the first channel that disagrees is recorded.
//
// Ports
//   clk_i, reset_n_i  ds clock; synchronous active-low reset
//   v_i/data_i/last_i per-channel beat stream (chan c data at [c*width_p +: width_p])
//   els_i/len_i       per-channel static config, 8 bits each per channel
//   ready_o           per-channel ready
//   v_o/data_o/last_o host-bound beat stream; ready_i is the downstream ready
//   err_o/err_chan_o  sticky length-mismatch flag and first offending channel
//   dbg_state_o       current FSM state (0 idle, 1 header, 2 body)
//
// Handshake: a beat moves on a cycle where valid and ready are both high at the
// clock edge. A producer that raises valid holds it and its data until accepted.
// Valid never depends on ready.
module bsg_cover_packetizer #(
  parameter int num_chan_p = 4,
  parameter int width_p    = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_chan_p-1:0]         v_i,
  input  logic [num_chan_p*width_p-1:0] data_i,
  input  logic [num_chan_p-1:0]         last_i,
  input  logic [num_chan_p*8-1:0]       els_i,
  input  logic [num_chan_p*8-1:0]       len_i,
  output logic [num_chan_p-1:0]         ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  output logic                          last_o,
  input  logic                          ready_i,
  output logic                          err_o,
  output logic [7:0]                    err_chan_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int sel_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [sel_w_lp-1:0]   r_sel;
  logic [sel_w_lp-1:0]   r_rr;
  logic [sel_w_lp-1:0]   w_gnt;
  logic [sel_w_lp-1:0]   w_rr_nxt;
  logic                  w_any;
  logic [15:0]           r_exp;
  logic [15:0]           r_cnt;
  logic                  r_err;
  logic [7:0]            r_err_chan;
  logic [width_p-1:0]    w_hdr;
  logic                  w_beat;

  // Per-channel views of the flat buses.
  logic [7:0]         w_els  [num_chan_p];
  logic [7:0]         w_len  [num_chan_p];
  logic [width_p-1:0] w_data [num_chan_p];

  for (genvar g = 0; g < num_chan_p; g++) begin : g_unpack
    assign w_els[g]  = els_i[g*8 +: 8];
    assign w_len[g]  = len_i[g*8 +: 8];
    assign w_data[g] = data_i[g*width_p +: width_p];
  end

  // Round-robin search: first requester at or after r_rr, wrapping at num_chan_p.
  // The index is one bit wider than the select so the wrap also works for
  // non-power-of-two channel counts.
  always_comb begin
    logic [sel_w_lp:0] idx;
    logic              found;
    w_gnt = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < num_chan_p; k++) begin
      idx = {1'b0, r_rr} + (sel_w_lp+1)'(k);
      if (idx >= (sel_w_lp+1)'(num_chan_p)) idx = idx - (sel_w_lp+1)'(num_chan_p);
      if (!found && v_i[idx[sel_w_lp-1:0]]) begin
        found = 1'b1;
        w_gnt = idx[sel_w_lp-1:0];
      end
    end
  end

  assign w_any    = |v_i;
  assign w_rr_nxt = (w_gnt == sel_w_lp'(num_chan_p - 1)) ? '0 : w_gnt + sel_w_lp'(1);

  always_comb begin
    w_hdr       = '0;
    w_hdr[23:0] = {8'(r_sel), w_els[r_sel], w_len[r_sel]};
  end

  assign w_beat = (r_state == BODY) && v_i[r_sel] && ready_i;

  always_comb begin
    w_state_nxt = r_state;
    v_o         = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    ready_o     = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = HDR;
      end
      HDR: begin
        v_o    = 1'b1;
        data_o = w_hdr;
        if (ready_i) w_state_nxt = BODY;
      end
      BODY: begin
        // Zero-latency passthrough of the granted channel.
        v_o            = v_i[r_sel];
        data_o         = w_data[r_sel];
        last_o         = last_i[r_sel];
        ready_o[r_sel] = ready_i;
        if (w_beat && last_i[r_sel]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_rr       <= '0;
      r_sel      <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_chan <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_sel <= w_gnt;
        r_exp <= 16'(w_els[w_gnt]) * 16'(w_len[w_gnt]);
        r_rr  <= w_rr_nxt;
      end
      if (r_state == HDR && ready_i) r_cnt <= '0;
      if (w_beat) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        // Compare against the count including this beat; 17 bits so a
        // saturated counter can never alias a matching length.
        if (last_i[r_sel] && !r_err && (({1'b0, r_cnt} + 17'd1) != {1'b0, r_exp})) begin
          r_err      <= 1'b1;
          r_err_chan <= 8'(r_sel);
        end
      end
    end
  end

  assign err_o       = r_err;
  assign err_chan_o  = r_err_chan;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bsg_cover_packetizer.sv
// Testbench for bsg_cover_packetizer. Channel bursts are loaded into per-channel
// beat memories; a transaction-level model walks the pending bursts in
// round-robin order to build the expected output stream (header then beats) and
// the expected error flag. The driver replays the bursts with optional valid gaps
// and ready patterns, and a scoreboard pops the expected queue on every accepted
// output beat.
module tb_bsg_cover_packetizer;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int QW    = W + 1;
  localparam int DEPTH = 64;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   last_i;
  logic [N*8-1:0] els_i;
  logic [N*8-1:0] len_i;
  logic [N-1:0]   ready_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           last_o;
  logic           ready_i;
  logic           err_o;
  logic [7:0]     err_chan_o;
  logic [1:0]     dbg_state;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] beat_mem   [N][DEPTH];
  bit           beat_last  [N][DEPTH];
  bit           beat_first [N][DEPTH];
  int           wr_ptr [N];
  int           rd_ptr [N];
  int           nb     [N];
  int           bl_len [N][16];
  bit           held   [N];

  logic [QW-1:0] exp_q[$];
  int            m_rr;
  bit            m_err;
  int            m_err_chan;

  bsg_cover_packetizer #(.num_chan_p(N), .width_p(W)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .v_i        (v_i),
    .data_i     (data_i),
    .last_i     (last_i),
    .els_i      (els_i),
    .len_i      (len_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .err_o      (err_o),
    .err_chan_o (err_chan_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v_i     = '0;
    data_i  = '0;
    last_i  = '0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    m_rr       = 0;
    m_err      = 1'b0;
    m_err_chan = 0;
  endtask

  // ---------------- driver helpers ----------------
  task automatic clear_bufs();
    for (int c = 0; c < N; c++) begin
      wr_ptr[c] = 0;
      rd_ptr[c] = 0;
      nb[c]     = 0;
      held[c]   = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic set_cfg(input int c, input int e, input int l);
    els_i[c*8 +: 8] = 8'(e);
    len_i[c*8 +: 8] = 8'(l);
  endtask

  task automatic add_burst(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      beat_mem[c][wr_ptr[c]]   = $urandom;
      beat_last[c][wr_ptr[c]]  = (i == n - 1);
      beat_first[c][wr_ptr[c]] = (i == 0);
      wr_ptr[c]++;
    end
    bl_len[c][nb[c]] = n;
    nb[c]++;
  endtask

  function automatic logic [W-1:0] hdr_of(input int c);
    logic [W-1:0] h;
    h       = '0;
    h[23:0] = {8'(c), els_i[c*8 +: 8], len_i[c*8 +: 8]};
    return h;
  endfunction

  // Replays all loaded bursts. ready_mode: 0 always ready, 1 toggle, 2 random.
  task automatic run_traffic(input int ready_mode, input bit gaps);
    int mptr [N];
    int mb   [N];
    int exp_cycles, cyc, pick, n, el, c;
    bit done, prev_stall, prev_last, drained;
    logic [W-1:0]  prev_data;
    logic [QW-1:0] e;

    // Reference model: serve pending bursts round-robin, header then beats.
    exp_cycles = 0;
    for (int i = 0; i < N; i++) begin
      mptr[i] = 0;
      mb[i]   = 0;
    end
    for (int t = 0; t < N * 16; t++) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (pick < 0 && mb[c] < nb[c]) pick = c;
      end
      if (pick >= 0) begin
        exp_q.push_back({1'b0, hdr_of(pick)});
        n = bl_len[pick][mb[pick]];
        for (int i = 0; i < n; i++)
          exp_q.push_back({(i == n - 1), beat_mem[pick][mptr[pick] + i]});
        mptr[pick] += n;
        mb[pick]++;
        el = int'(els_i[pick*8 +: 8]) * int'(len_i[pick*8 +: 8]);
        if (!m_err && n != el) begin
          m_err      = 1'b1;
          m_err_chan = pick;
        end
        m_rr       = (pick + 1) % N;
        exp_cycles += 2 + n;
      end
    end

    cyc        = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_last  = 1'b0;
    prev_data  = '0;
    if (ready_mode == 1) ready_i = 1'b0;
    while (!done && cyc < 2000) begin
      cyc++;
      for (int ch = 0; ch < N; ch++) begin
        if (rd_ptr[ch] < wr_ptr[ch]) begin
          v_i[ch] = held[ch] || beat_first[ch][rd_ptr[ch]] || !gaps || ($urandom_range(0, 3) != 0);
          data_i[ch*W +: W] = beat_mem[ch][rd_ptr[ch]];
          last_i[ch] = beat_last[ch][rd_ptr[ch]];
        end else begin
          v_i[ch]    = 1'b0;
          last_i[ch] = 1'b0;
        end
      end
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ~ready_i;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall) begin
        checks++;
        if (v_o !== 1'b1 || data_o !== prev_data || last_o !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b data=%h last=%b, expected v=1 data=%h last=%b",
                   v_o, data_o, last_o, prev_data, prev_last);
        end
      end
      for (int ch = 0; ch < N; ch++) begin
        if (v_i[ch] && ready_o[ch] === 1'b1) begin
          rd_ptr[ch]++;
          held[ch] = 1'b0;
        end else begin
          held[ch] = v_i[ch];
        end
      end
      if (v_o === 1'b1 && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h, expected no beat", {last_o, data_o});
        end else begin
          e = exp_q.pop_front();
          if ({last_o, data_o} !== e) begin
            errors++;
            $display("FAIL beat: got last/data %h, expected %h", {last_o, data_o}, e);
          end
        end
      end
      prev_stall = (v_o === 1'b1) && !ready_i;
      prev_data  = data_o;
      prev_last  = last_o;
      drained    = 1'b1;
      for (int ch = 0; ch < N; ch++) if (rd_ptr[ch] != wr_ptr[ch]) drained = 1'b0;
      done = drained && (exp_q.size() == 0);
      @(negedge clk);
    end
    v_i     = '0;
    last_i  = '0;
    ready_i = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got %0d beats outstanding after %0d cycles, expected 0", exp_q.size(), cyc);
      exp_q.delete();
    end else if (ready_mode == 0 && !gaps) begin
      checks++;
      if (cyc != exp_cycles) begin
        errors++;
        $display("FAIL cycle_count: got %0d, expected %0d", cyc, exp_cycles);
      end
    end
    checks += 2;
    if (err_o !== m_err) begin
      errors++;
      $display("FAIL err_o: got %b, expected %b", err_o, m_err);
    end
    if (err_chan_o !== 8'(m_err_chan)) begin
      errors++;
      $display("FAIL err_chan_o: got %0d, expected %0d", err_chan_o, m_err_chan);
    end
    clear_bufs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v_i     = '1;
    last_i  = '1;
    data_i  = {$urandom, $urandom, $urandom, $urandom};
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks += 5;
    if (v_o !== 1'b0)        begin errors++; $display("FAIL rst_v_o: got %b, expected 0", v_o); end
    if (ready_o !== '0)      begin errors++; $display("FAIL rst_ready_o: got %b, expected 0", ready_o); end
    if (last_o !== 1'b0)     begin errors++; $display("FAIL rst_last_o: got %b, expected 0", last_o); end
    if (err_o !== 1'b0)      begin errors++; $display("FAIL rst_err_o: got %b, expected 0", err_o); end
    if (err_chan_o !== 8'd0) begin errors++; $display("FAIL rst_err_chan: got %0d, expected 0", err_chan_o); end
    // First cycle after release is still the grant cycle: nothing offered or consumed.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks += 2;
    if (v_o !== 1'b0)   begin errors++; $display("FAIL idle_v_o: got %b, expected 0", v_o); end
    if (ready_o !== '0) begin errors++; $display("FAIL idle_ready_o: got %b, expected 0", ready_o); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    clear_bufs();
    set_cfg(0, 2, 2);
    add_burst(0, 4);
    run_traffic(0, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    clear_bufs();
    set_cfg(0, 1, 2);
    set_cfg(1, 2, 1);
    add_burst(0, 2);
    add_burst(1, 2);
    run_traffic(0, 1'b0);
  endtask

  task automatic test_rr_fairness();
    do_reset();
    clear_bufs();
    set_cfg(0, 1, 3);
    set_cfg(2, 3, 1);
    add_burst(0, 3);
    add_burst(0, 3);
    add_burst(2, 3);
    run_traffic(0, 1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    clear_bufs();
    set_cfg(1, 2, 3);
    set_cfg(3, 1, 4);
    add_burst(1, 6);
    add_burst(3, 4);
    run_traffic(1, 1'b0);
  endtask

  task automatic test_mismatch();
    do_reset();
    clear_bufs();
    set_cfg(3, 2, 2);
    set_cfg(1, 1, 2);
    add_burst(3, 3);
    run_traffic(0, 1'b0);
    add_burst(1, 1);
    run_traffic(0, 1'b0);
  endtask

  task automatic test_zero_exp();
    do_reset();
    clear_bufs();
    set_cfg(2, 0, 3);
    add_burst(2, 1);
    run_traffic(2, 1'b0);
  endtask

  // Runs straight after test_zero_exp so err_o is set going in.
  task automatic test_reset_mid_body();
    logic [W-1:0] d2, d0;
    d2 = $urandom;
    d0 = $urandom;
    set_cfg(2, 1, 3);
    set_cfg(0, 2, 2);
    v_i              = 4'b0100;
    data_i[2*W +: W] = d2;
    last_i           = '0;
    ready_i          = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (v_o !== 1'b1 || data_o !== hdr_of(2)) begin
      errors++;
      $display("FAIL mid_hdr: got v=%b data=%h, expected v=1 data=%h", v_o, data_o, hdr_of(2));
    end
    @(negedge clk);
    #1;
    checks++;
    if (v_o !== 1'b1 || data_o !== d2 || ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL mid_body: got v=%b data=%h ready=%b, expected v=1 data=%h ready=0100",
               v_o, data_o, ready_o, d2);
    end
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks += 3;
    if (v_o !== 1'b0)   begin errors++; $display("FAIL mid_rst_v_o: got %b, expected 0", v_o); end
    if (ready_o !== '0) begin errors++; $display("FAIL mid_rst_ready: got %b, expected 0", ready_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b, expected 0", err_o); end
    reset_n          = 1'b1;
    v_i              = 4'b0101;
    data_i[0*W +: W] = d0;
    @(negedge clk);
    #1;
    checks++;
    if (v_o !== 1'b1 || data_o !== hdr_of(0)) begin
      errors++;
      $display("FAIL restart_hdr: got v=%b data=%h, expected v=1 data=%h", v_o, data_o, hdr_of(0));
    end
    do_reset();
  endtask

  task automatic test_random();
    int e, l, nbur, n;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      clear_bufs();
      for (int c = 0; c < N; c++) set_cfg(c, $urandom_range(0, 3), $urandom_range(1, 3));
      for (int c = 0; c < N; c++) begin
        e    = int'(els_i[c*8 +: 8]);
        l    = int'(len_i[c*8 +: 8]);
        nbur = $urandom_range(0, 3);
        for (int b = 0; b < nbur; b++) begin
          n = (e * l > 0 && $urandom_range(0, 3) != 0) ? e * l : $urandom_range(1, 6);
          add_burst(c, n);
        end
      end
      run_traffic((r == 0) ? 0 : 2, r != 0);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset_n = 1'b0;
    v_i     = '0;
    data_i  = '0;
    last_i  = '0;
    els_i   = '0;
    len_i   = '0;
    ready_i = 1'b0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_rr_fairness();
    test_stall();
    test_mismatch();
    test_zero_exp();
    test_reset_mid_body();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
